// File: rtl/tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter_if
// Brief    : Request, serial-sender and status bundle of the TX arbiter.
// Revision : 1.0
// ============================================================================
interface tx_arbiter_if #(
  parameter int PAYLOAD_W = 24
);
  logic                 game_active;
  logic                 ack_req;
  logic [3:0]           ack_seq;
  logic                 data_req;
  logic                 data_retx;
  logic [PAYLOAD_W-1:0] data_in;
  logic                 ser_done;
  logic                 ser_start;
  logic [PAYLOAD_W+5:0] ser_pkt;
  logic                 data_done;
  logic                 ack_done;
  logic                 busy;
  logic                 ser_err;

  modport master (
    output game_active, ack_req, ack_seq, data_req, data_retx, data_in, ser_done,
    input  ser_start, ser_pkt, data_done, ack_done, busy, ser_err
  );

  modport slave (
    input  game_active, ack_req, ack_seq, data_req, data_retx, data_in, ser_done,
    output ser_start, ser_pkt, data_done, ack_done, busy, ser_err
  );
endinterface
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Brief    : Grants ACK and data packets to one serial sender, with watchdog.
// Revision : 1.0
// ============================================================================
module tx_arbiter #(
  parameter int PAYLOAD_W   = 24,
  parameter int SER_TIMEOUT = 4096
) (
  input  wire logic   clk,
  input  wire logic   rst_l,
  tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND_ACK  = 2'd1,
    S_SEND_DATA = 2'd2
  } state_t;

  localparam logic c_GRANT_ACK  = 1'b1;
  localparam logic c_GRANT_DATA = 1'b0;
  localparam int   c_WD_W       = $clog2(SER_TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(SER_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ack_pend;
  logic                 r_data_pend;
  logic                 r_last_grant;
  logic [3:0]           r_ack_seq;
  logic [3:0]           r_data_seq;
  logic [3:0]           r_tx_seq;
  logic [PAYLOAD_W-1:0] r_data_pl;
  logic [c_WD_W-1:0]    r_wdog;
  logic [PAYLOAD_W+5:0] r_ser_pkt;
  logic                 r_ser_start;
  logic                 r_ack_done;
  logic                 r_data_done;
  logic                 r_ser_err;
  logic                 w_ack_in;
  logic                 w_data_in;
  logic                 w_grant_ack;
  logic                 w_grant_data;
  logic                 w_finish;
  logic                 w_abort;

  assign w_ack_in  = bus.game_active & bus.ack_req;
  assign w_data_in = bus.game_active & bus.data_req;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_ack  = 1'b0;
    w_grant_data = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.game_active) begin
          // On a tie the type not granted last wins.
          if (r_ack_pend && (!r_data_pend || r_last_grant == c_GRANT_DATA)) begin
            w_grant_ack = 1'b1;
            w_state_nxt = S_SEND_ACK;
          end else if (r_data_pend) begin
            w_grant_data = 1'b1;
            w_state_nxt  = S_SEND_DATA;
          end
        end
      end
      S_SEND_ACK, S_SEND_DATA: begin
        // The ser_start cycle belongs to the new packet; ser_done there is stale.
        if (!r_ser_start) begin
          if (bus.ser_done) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_wdog >= c_WD_LAST) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ack_pend   <= 1'b0;
      r_data_pend  <= 1'b0;
      r_last_grant <= c_GRANT_DATA;
      r_ack_seq    <= 4'd0;
      r_data_seq   <= 4'd0;
      r_tx_seq     <= 4'd0;
      r_data_pl    <= '0;
      r_wdog       <= '0;
      r_ser_pkt    <= '0;
      r_ser_start  <= 1'b0;
      r_ack_done   <= 1'b0;
      r_data_done  <= 1'b0;
      r_ser_err    <= 1'b0;
    end else begin
      // A request in the grant cycle re-arms the flag for the next grant.
      if (!bus.game_active)  r_ack_pend <= 1'b0;
      else if (bus.ack_req)  r_ack_pend <= 1'b1;
      else if (w_grant_ack)  r_ack_pend <= 1'b0;

      if (!bus.game_active)  r_data_pend <= 1'b0;
      else if (bus.data_req) r_data_pend <= 1'b1;
      else if (w_grant_data) r_data_pend <= 1'b0;

      if (w_ack_in) r_ack_seq <= bus.ack_seq;

      if (w_data_in) begin
        r_data_pl <= bus.data_in;
        if (bus.data_retx) begin
          r_data_seq <= r_tx_seq;
        end else begin
          r_tx_seq   <= r_tx_seq + 4'd1;
          r_data_seq <= r_tx_seq + 4'd1;
        end
      end

      r_ser_start <= w_grant_ack | w_grant_data;
      if (w_grant_ack) begin
        r_ser_pkt    <= {2'b10, r_ack_seq, {PAYLOAD_W{1'b0}}};
        r_last_grant <= c_GRANT_ACK;
      end else if (w_grant_data) begin
        r_ser_pkt    <= {2'b01, r_data_seq, r_data_pl};
        r_last_grant <= c_GRANT_DATA;
      end

      if (w_grant_ack | w_grant_data) r_wdog <= '0;
      else if (r_state != S_IDLE)     r_wdog <= r_wdog + c_WD_W'(1);

      r_ack_done  <= w_finish & (r_state == S_SEND_ACK);
      r_data_done <= w_finish & (r_state == S_SEND_DATA);
      r_ser_err   <= w_abort;
    end
  end

  assign bus.ser_start = r_ser_start;
  assign bus.ser_pkt   = r_ser_pkt;
  assign bus.ack_done  = r_ack_done;
  assign bus.data_done = r_data_done;
  assign bus.ser_err   = r_ser_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Brief    : Self-checking bench for tx_arbiter with a packet scoreboard.
// Revision : 1.0
// ============================================================================
module tb_tx_arbiter;

  localparam int PAYLOAD_W   = 24;
  localparam int SER_TIMEOUT = 32;
  localparam int c_PKT_W     = PAYLOAD_W + 6;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  tx_arbiter_if #(.PAYLOAD_W(PAYLOAD_W)) bus ();

  tx_arbiter #(
    .PAYLOAD_W  (PAYLOAD_W),
    .SER_TIMEOUT(SER_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  typedef struct {
    bit                 ack;
    logic [3:0]         aseq;
    bit                 data;
    bit                 retx;
    logic [23:0]        din;
    logic [c_PKT_W-1:0] pkt;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_start  = 0;
  int n_ack    = 0;
  int n_data   = 0;
  int n_err    = 0;
  int done_cyc = -10;
  int err_cyc  = 0;
  int done_delay = 10;
  bit hold_done  = 1'b0;
  int rcnt       = 0;
  logic [c_PKT_W-1:0] sb[$];
  logic [3:0] exp_seq = 4'd0;
  vec_t vt[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_data(input bit retx, input logic [23:0] din);
    bus.data_req  = 1'b1;
    bus.data_retx = retx;
    bus.data_in   = din;
    tick();
    bus.data_req  = 1'b0;
  endtask

  task automatic pulse_ack(input logic [3:0] seq);
    bus.ack_req = 1'b1;
    bus.ack_seq = seq;
    tick();
    bus.ack_req = 1'b0;
  endtask

  task automatic wait_quiet(input int maxc);
    int q;
    bit ok;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (!bus.busy && sb.size() == 0) q++;
      else q = 0;
      if (q >= 3) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_quiet actual=busy%0d_queued%0d required=idle", bus.busy, sb.size());
    end
  endtask

  // Serial sender model: answers each ser_start with ser_done done_delay cycles later.
  always @(posedge clk) begin
    #1;
    bus.ser_done = 1'b0;
    if (!rst_l) begin
      rcnt = 0;
    end else if (bus.ser_start) begin
      rcnt = done_delay;
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0 && !hold_done) bus.ser_done = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every grant and times the done pulses.
  always @(posedge clk) begin
    #3;
    if (rst_l) begin
      if (bus.ser_start) begin
        n_start++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ser_start_unexpected actual=%0h required=none", bus.ser_pkt);
        end else begin
          chk("ser_pkt", bus.ser_pkt, sb.pop_front());
        end
      end
      if (bus.ser_done) done_cyc = cyc;
      if (bus.ack_done) begin
        n_ack++;
        chk("ack_done_lat", cyc, done_cyc + 1);
      end
      if (bus.data_done) begin
        n_data++;
        chk("data_done_lat", cyc, done_cyc + 1);
      end
      if (bus.ser_err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s, n0, e0, a0, s0;
    bus.game_active = 1'b0;
    bus.ack_req     = 1'b0;
    bus.ack_seq     = 4'd0;
    bus.data_req    = 1'b0;
    bus.data_retx   = 1'b0;
    bus.data_in     = '0;

    vt[0] = '{1'b1, 4'h5, 1'b0, 1'b0, 24'h000000, {2'b10, 4'h5, 24'h000000}};
    vt[1] = '{1'b0, 4'h0, 1'b1, 1'b0, 24'h123456, {2'b01, 4'h2, 24'h123456}};
    vt[2] = '{1'b0, 4'h0, 1'b1, 1'b1, 24'h654321, {2'b01, 4'h2, 24'h654321}};
    vt[3] = '{1'b1, 4'hF, 1'b0, 1'b0, 24'h000000, {2'b10, 4'hF, 24'h000000}};
    vt[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 24'hFFFFFF, {2'b01, 4'h3, 24'hFFFFFF}};
    vt[5] = '{1'b0, 4'h0, 1'b1, 1'b0, 24'h000000, {2'b01, 4'h4, 24'h000000}};

    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_ser_start", bus.ser_start, 0);
    chk("rst_ser_pkt", bus.ser_pkt, 0);
    chk("rst_ack_done", bus.ack_done, 0);
    chk("rst_data_done", bus.data_done, 0);
    chk("rst_ser_err", bus.ser_err, 0);
    rst_l = 1'b1;
    tick();
    bus.game_active = 1'b1;
    tick();

    // Basic data packet, latency k+2, first seq is 1.
    exp_seq++;
    sb.push_back({2'b01, exp_seq, 24'hABCDEF});
    pulse_data(1'b0, 24'hABCDEF);
    chk("start_k1", bus.ser_start, 0);
    tick();
    chk("start_k2", bus.ser_start, 1);
    chk("busy_send", bus.busy, 1);
    wait_quiet(40);
    chk("data_done_cnt", n_data, 1);

    for (int i = 0; i < 6; i++) begin
      sb.push_back(vt[i].pkt);
      bus.ack_req   = vt[i].ack;
      bus.ack_seq   = vt[i].aseq;
      bus.data_req  = vt[i].data;
      bus.data_retx = vt[i].retx;
      bus.data_in   = vt[i].din;
      tick();
      bus.ack_req  = 1'b0;
      bus.data_req = 1'b0;
      tick();
      chk($sformatf("vec%0d_start", i), bus.ser_start, 1);
      wait_quiet(40);
    end
    chk("vec_ack_cnt", n_ack, 2);
    chk("vec_data_cnt", n_data, 5);
    exp_seq = 4'd4;

    // Simultaneous requests: ACK first, then alternation on repeated ties.
    exp_seq++;
    sb.push_back({2'b10, 4'h5, 24'h000000});
    sb.push_back({2'b01, exp_seq, 24'h111111});
    bus.ack_req = 1'b1; bus.ack_seq = 4'h5;
    bus.data_req = 1'b1; bus.data_retx = 1'b0; bus.data_in = 24'h111111;
    tick();
    bus.ack_req = 1'b0; bus.data_req = 1'b0;
    tick();
    chk("tie_start", bus.ser_start, 1);
    chk("tie_ack_first", bus.ser_pkt[c_PKT_W-1 -: 2], 2'b10);
    a0 = n_ack;
    for (int k = 0; k < 30 && n_ack == a0; k++) tick();
    repeat (3) tick();
    chk("tie_data_inflight", bus.busy, 1);
    exp_seq++;
    sb.push_back({2'b10, 4'h7, 24'h000000});
    sb.push_back({2'b01, exp_seq, 24'h222222});
    bus.ack_req = 1'b1; bus.ack_seq = 4'h7;
    bus.data_req = 1'b1; bus.data_retx = 1'b0; bus.data_in = 24'h222222;
    tick();
    bus.ack_req = 1'b0; bus.data_req = 1'b0;
    wait_quiet(80);

    // Sixteen new packets walk the sequence through the 15 -> 0 wrap.
    done_delay = 3;
    for (int i = 0; i < 16; i++) begin
      exp_seq++;
      sb.push_back({2'b01, exp_seq, 24'(i * 4097)});
      pulse_data(1'b0, 24'(i * 4097));
      wait_quiet(30);
    end
    done_delay = 10;

    // Watchdog abort with an ACK waiting behind it.
    hold_done = 1'b1;
    exp_seq++;
    sb.push_back({2'b01, exp_seq, 24'h5A5A5A});
    pulse_data(1'b0, 24'h5A5A5A);
    tick();
    chk("to_start", bus.ser_start, 1);
    s = cyc;
    sb.push_back({2'b10, 4'h9, 24'h000000});
    pulse_ack(4'h9);
    n0 = n_data; e0 = n_err; a0 = n_ack;
    for (int k = 0; k < SER_TIMEOUT + 20 && n_err == e0; k++) tick();
    chk("to_err_cnt", n_err, e0 + 1);
    chk("to_err_lat", err_cyc - s, SER_TIMEOUT);
    hold_done = 1'b0;
    wait_quiet(60);
    chk("to_no_data_done", n_data, n0);
    chk("to_ack_after", n_ack, a0 + 1);

    // game_active falls mid-send: data completes, pending ACK is dropped.
    exp_seq++;
    sb.push_back({2'b01, exp_seq, 24'hC0FFEE});
    pulse_data(1'b0, 24'hC0FFEE);
    tick();
    chk("ga_start", bus.ser_start, 1);
    pulse_ack(4'h3);
    bus.game_active = 1'b0;
    n0 = n_data;
    for (int k = 0; k < 30 && n_data == n0; k++) tick();
    chk("ga_data_done", n_data, n0 + 1);
    repeat (3) tick();
    chk("ga_busy_low", bus.busy, 0);
    s0 = n_start;
    pulse_data(1'b0, 24'h777777);
    repeat (10) tick();
    chk("ga_no_grant_inactive", n_start, s0);
    bus.game_active = 1'b1;
    repeat (10) tick();
    chk("ga_no_grant_reactivated", n_start, s0);
    chk("ga_busy_idle", bus.busy, 0);
    exp_seq++;
    sb.push_back({2'b01, exp_seq, 24'h0DD0DD});
    pulse_data(1'b0, 24'h0DD0DD);
    wait_quiet(40);

    // Reset in the middle of an ACK send.
    sb.push_back({2'b10, 4'hE, 24'h000000});
    pulse_ack(4'hE);
    tick();
    chk("rs_start", bus.ser_start, 1);
    repeat (3) tick();
    a0 = n_ack;
    rst_l = 1'b0;
    #1;
    chk("rs_busy", bus.busy, 0);
    chk("rs_ser_pkt", bus.ser_pkt, 0);
    chk("rs_ser_start", bus.ser_start, 0);
    chk("rs_ack_done", bus.ack_done, 0);
    repeat (2) tick();
    rst_l = 1'b1;
    s0 = n_start;
    repeat (20) tick();
    chk("rs_no_ack_done", n_ack, a0);
    chk("rs_no_grant", n_start, s0);
    exp_seq = 4'd0;
    exp_seq++;
    sb.push_back({2'b01, exp_seq, 24'h0BEEF0});
    pulse_data(1'b0, 24'h0BEEF0);
    wait_quiet(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter PAYLOAD_W, default 24: data payload width in bits.
REQ-002 Parameter SER_TIMEOUT, default 4096: maximum clk cycles to wait for ser_done before aborting a grant.
REQ-003 Port clk, input, 1: GPIO clock; all logic is posedge clk.
REQ-004 Port rst_l, input, 1: asynchronous, active-low reset.
REQ-005 Port game_active, input, 1: level; game in progress.
REQ-006 Port ack_req, input, 1: 1-cycle pulse; receiver requests an ACK send.
REQ-007 Port ack_seq, input, 4: sequence number to acknowledge; sampled with ack_req.
REQ-008 Port data_req, input, 1: 1-cycle pulse from the data sender FSM's send_start.
REQ-009 Port data_retx, input, 1: sampled with data_req; 1 = retransmit (reuse seq), 0 = new packet.
REQ-010 Port data_in, input, PAYLOAD_W: game payload; sampled with data_req.
REQ-011 Port ser_done, input, 1: 1-cycle pulse; serial sender finished the current packet.
REQ-012 Port ser_start, output, 1: 1-cycle pulse; serial sender loads ser_pkt and begins.
REQ-013 Port ser_pkt, output, PAYLOAD_W+6: {type[1:0], seq[3:0], payload}.
REQ-014 Port data_done, output, 1: 1-cycle pulse; data packet sent (drives the data FSM's send_done).
REQ-015 Port ack_done, output, 1: 1-cycle pulse; ACK packet sent.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.
REQ-017 Port ser_err, output, 1: 1-cycle pulse on serial-sender timeout.

Function
REQ-018 States: IDLE, SEND_ACK, SEND_DATA.
REQ-019 ack_req sets ack_pend and latches ack_seq; a new ack_req while ack_pend is set overwrites the latched seq (newest ACK wins).
REQ-020 data_req sets data_pend and latches data_in; a new data_req while data_pend is set overwrites the payload.
REQ-021 tx_seq, 4 bits, reset 0: incremented mod 16 (15->0) when data_req is sampled with data_retx=0; unchanged when data_retx=1; latched as the data packet seq.
REQ-022 IDLE: if only ack_pend, go to SEND_ACK; if only data_pend, go to SEND_DATA; if both, go to the type not granted last (last_grant flop, reset = DATA, so ACK wins first).
REQ-023 On the transition into SEND_x: ser_start = 1 for exactly one cycle; the corresponding pend flag is cleared; ser_pkt is loaded and held stable until the next grant.
REQ-024 ACK packet: type 2'b10, seq = latched ack_seq, payload all zeros. Data packet: type 2'b01, seq = latched data seq, payload = latched data_in.
REQ-025 Latency: a req pulse in cycle k with arbiter in IDLE gives ser_start in cycle k+2.
REQ-026 SEND_x: on ser_done, return to IDLE; the cycle after ser_done, pulse ack_done (SEND_ACK) or data_done (SEND_DATA).
REQ-027 A req arriving in the same cycle as ser_done sets its pend flag normally; it is not lost.
REQ-028 The ser_start pulse cycle ignores ser_done.
REQ-029 Watchdog counter cleared on grant, counts in SEND_x; on reaching SER_TIMEOUT, return to IDLE, pulse ser_err, and suppress the done pulse; the pend flag stays cleared.
REQ-030 game_active low: clear ack_pend and data_pend and ignore new reqs; any in-flight SEND_x completes normally, including its done pulse.
REQ-031 While game_active is low, no new grant is issued.

Reset
REQ-032 While rst_l is low: state = IDLE, pend flags = 0, tx_seq = 0, last_grant = DATA, watchdog = 0, ser_pkt = 0, and all pulse outputs and busy = 0.
REQ-033 Reset mid-SEND abandons the transaction with no done pulse; the first grant after reset is issued only on a new req.

Verification
REQ-034 game_active=1, data_req with data_retx=0, data_in=24'hABCDEF, ser_done 10 cycles after ser_start -> ser_start at k+2, ser_pkt = {2'b01, 4'h1, 24'hABCDEF}, data_done one cycle after ser_done.
REQ-035 ack_req (seq 4'h5) and data_req in the same cycle -> ACK {2'b10, 4'h5, 0} granted first, then data; with both repeatedly pending, grants alternate ACK, DATA, ACK.
REQ-036 Retransmit: data_req with data_retx=0 then data_retx=1 -> both packets carry the same seq; 16 new packets make seq wrap 4'hF -> 4'h0.
REQ-037 Withhold ser_done for SER_TIMEOUT cycles -> ser_err pulse, return to IDLE, no data_done; the next pending request is then granted.
REQ-038 game_active falls during SEND_DATA with an ACK pending -> data_done still pulses; the ACK is dropped; busy = 0 afterward; no ser_start until game_active=1 and a new req.
REQ-039 Assert rst_l low mid-SEND_ACK -> all outputs 0 at once; no ack_done after release.
